// File: rtl/vector_cache_pkg.sv
// vector_cache_pkg: source indices, per-source write-command timing and the
// request payload shared by the vector cache write path.
package vector_cache_pkg;
   localparam int NUM_SRC = 5;
   localparam int SRC_WEST = 0;
   localparam int SRC_EAST = 1;
   localparam int SRC_SOUTH = 2;
   localparam int SRC_NORTH = 3;
   localparam int SRC_LF = 4;
   localparam int WR_CMD_DELAY_WEST = 2;
   localparam int WR_CMD_DELAY_EAST = 3;
   localparam int WR_CMD_DELAY_SOUTH = 6;
   localparam int WR_CMD_DELAY_NORTH = 4;
   localparam int WR_CMD_DELAY_LF = 8;
   localparam int DS_N = 4;
   localparam int MAX_SPAN = WR_CMD_DELAY_LF + DS_N;

   typedef struct packed {
      logic [3:0] dest_ram_id;
      logic [11:0] addr;
      logic [31:0] data;
   } arb_out_req_t;

   function automatic int src_delay(input int s);
      return s == SRC_WEST ? WR_CMD_DELAY_WEST :
             s == SRC_EAST ? WR_CMD_DELAY_EAST :
             s == SRC_SOUTH ? WR_CMD_DELAY_SOUTH :
             s == SRC_NORTH ? WR_CMD_DELAY_NORTH : WR_CMD_DELAY_LF;
   endfunction

   function automatic int src_len(input int s);
      return s == SRC_LF ? DS_N : 1;
   endfunction
endpackage

// File: rtl/vec_rr_arb5.sv
// vec_rr_arb5: 5-way round-robin arbiter; priority starts at ptr and wraps 4->0.
module vec_rr_arb5 (
   input logic [4:0] req,
   input logic [2:0] ptr,
   output logic [4:0] gnt
);
   logic found;

   always_comb begin
      gnt = '0;
      found = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (i >= int'(ptr) && !found && req[i % 5]) begin
            gnt[i % 5] = 1'b1;
            found = 1'b1;
         end
      end
   end
endmodule

// File: rtl/vec_wr_chan_sched.sv
// vec_wr_chan_sched: grants one write source per cycle onto an SRAM channel,
// tracking future channel use in a per-channel shifting reservation window.
module vec_wr_chan_sched
   import vector_cache_pkg::*;
#(
   parameter int CHANNEL = 8,
   parameter int RESV_WIN = 16
) (
   input logic clk,
   input logic rst,
   input logic [NUM_SRC-1:0] req_vld,
   input arb_out_req_t req_pld [NUM_SRC],
   output logic [NUM_SRC-1:0] req_rdy,
   output logic out_vld,
   output arb_out_req_t out_pld,
   output logic [2:0] out_src,
   output logic [CHANNEL-1:0] ch_occ
);
   logic [RESV_WIN-1:0] resv [CHANNEL];
   logic [RESV_WIN-1:0] gmask [CHANNEL];
   logic [RESV_WIN-1:0] mask [NUM_SRC];
   logic [2:0] ch [NUM_SRC];
   logic [NUM_SRC-1:0] elig, gnt;
   logic [2:0] rr_ptr, gidx;

   function automatic logic [RESV_WIN-1:0] win_mask(input int d, input int l);
      win_mask = '0;
      for (int k = d; k < d + l; k++) win_mask[k] = 1'b1;
   endfunction

   if (RESV_WIN < MAX_SPAN) begin : g_win_chk
      $error("RESV_WIN too small for the longest source window");
   end
   if (CHANNEL < 1 || CHANNEL > 8) begin : g_ch_chk
      $error("CHANNEL must be 1..8 to match the 3-bit channel select");
   end

   for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
      assign ch[s] = req_pld[s].dest_ram_id[2:0];
      assign mask[s] = win_mask(src_delay(s), src_len(s));
      assign elig[s] = req_vld[s] && int'(ch[s]) < CHANNEL && (resv[ch[s]] & mask[s]) == '0;
   end

   vec_rr_arb5 u_arb (
      .req(elig & {NUM_SRC{~rst}}),
      .ptr(rr_ptr),
      .gnt(gnt)
   );

   assign req_rdy = gnt;

   always_comb begin
      gidx = '0;
      for (int s = 0; s < NUM_SRC; s++) if (gnt[s]) gidx = 3'(s);
   end

   // Only the single granted source can contribute a window to its channel.
   always_comb begin
      for (int c = 0; c < CHANNEL; c++) begin
         gmask[c] = '0;
         for (int s = 0; s < NUM_SRC; s++)
            gmask[c] = gnt[s] && ch[s] == 3'(c) ? gmask[c] | mask[s] : gmask[c];
         ch_occ[c] = resv[c][0] & ~rst;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int c = 0; c < CHANNEL; c++) resv[c] <= '0;
         rr_ptr <= '0;
         out_vld <= 1'b0;
         out_src <= '0;
         out_pld <= '0;
      end else begin
         for (int c = 0; c < CHANNEL; c++) resv[c] <= (resv[c] | gmask[c]) >> 1;
         rr_ptr <= |gnt ? (gidx == 3'd4 ? 3'd0 : gidx + 3'd1) : rr_ptr;
         out_vld <= |gnt;
         if (|gnt) begin
            out_src <= gidx;
            out_pld <= req_pld[gidx];
         end
      end
   end
endmodule
